// File: rtl/dm_tlv5619_frame_player.sv
// Ping-pong frame buffer feeding a TLV5619 DAC: one sample per SAMPLE_PERIOD clocks, DAC_DATA valid 2 clocks
// after SAMPLE_TICK, WE strobe at WE_START; optional DAC_UNDERRUN_MUTE_EN mutes a frame replayed after underrun.
module dm_tlv5619_frame_player #(
   parameter int DATA_W        = 12,
   parameter int ADDR_W        = 9,
   parameter int SAMPLE_PERIOD = 8192,
   parameter int WE_START      = 8,
   parameter int WE_LEN        = 8,
   parameter int MIDSCALE      = 2048
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              ENABLE,
   input  logic              WR_EN,
   input  logic [ADDR_W-1:0] WR_INDEX,
   input  logic [DATA_W-1:0] WR_DATA,
   input  logic              WR_FRAME_DONE,
   output logic              SAMPLE_TICK,
   output logic [ADDR_W-1:0] READ_INDEX,
   output logic              PLAY_BANK,
   output logic              UNDERRUN,
   output logic              OVERRUN,
   output logic [DATA_W-1:0] DAC_DATA,
   output logic              DAC_WE_N,
   output logic              DAC_CS_N,
   output logic              DAC_LDAC_N,
   output logic              DAC_PD_N
);

   localparam int CNT_W = $clog2(SAMPLE_PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
   localparam logic [CNT_W-1:0] WE_ON    = CNT_W'(WE_START);
   localparam logic [CNT_W-1:0] WE_OFF   = CNT_W'(WE_START + WE_LEN);
   localparam logic [DATA_W-1:0] SILENCE = DATA_W'(MIDSCALE);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, SETUP, STROBE} state_t;

   state_t            state, stateNext;
   logic [CNT_W-1:0]  cnt, cntNext;
   logic [ADDR_W-1:0] readIndex;
   logic              playBank, pending;
   logic              sampleEnd, frameEnd, swapNow;
   logic [DATA_W-1:0] dacData;
   logic              weN, underrunQ, overrunQ;
   logic [DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];
   logic [DATA_W-1:0] ramQ;
`ifdef DAC_UNDERRUN_MUTE_EN
   logic              muteQ;
`endif

   always_comb begin
      sampleEnd = (state != IDLE) && ENABLE && (cnt == CNT_LAST);
      frameEnd  = sampleEnd && (&readIndex);
      swapNow   = frameEnd && pending;
      cntNext   = (!ENABLE || state == IDLE || cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
   end

   // Phase follows the counter value the next cycle will hold; ENABLE low parks in IDLE.
   always_comb begin
      stateNext = IDLE;
      if (ENABLE) begin
         if (cntNext < CNT_W'(2))                       stateNext = FETCH;
         else if (cntNext == CNT_W'(2))                 stateNext = LOAD;
         else if (cntNext >= WE_ON && cntNext < WE_OFF) stateNext = STROBE;
         else                                           stateNext = SETUP;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= IDLE;
         cnt       <= '0;
         readIndex <= '0;
         playBank  <= 1'b0;
         pending   <= 1'b0;
         dacData   <= SILENCE;
         weN       <= 1'b1;
         underrunQ <= 1'b0;
         overrunQ  <= 1'b0;
`ifdef DAC_UNDERRUN_MUTE_EN
         muteQ     <= 1'b0;
`endif
      end else begin
         state     <= stateNext;
         cnt       <= cntNext;
         weN       <= (stateNext != STROBE);
         underrunQ <= frameEnd && !pending;
         overrunQ  <= WR_FRAME_DONE && pending && !swapNow;
         if (sampleEnd)
            readIndex <= readIndex + ADDR_W'(1);
         if (swapNow)
            playBank <= ~playBank;
         // A frame-done on the swap edge queues the next frame for the new write bank.
         if (WR_FRAME_DONE)
            pending <= 1'b1;
         else if (swapNow)
            pending <= 1'b0;
`ifdef DAC_UNDERRUN_MUTE_EN
         if (swapNow)
            muteQ <= 1'b0;
         else if (frameEnd)
            muteQ <= 1'b1;
         if (stateNext == LOAD)
            dacData <= muteQ ? SILENCE : ramQ;
`else
         if (stateNext == LOAD)
            dacData <= ramQ;
`endif
      end
   end

   // Writes use the bank index before the edge, so a swap-edge write lands in the old write bank.
   always_ff @(posedge CLK) begin
      if (WR_EN)
         mem[{~playBank, WR_INDEX}] <= WR_DATA;
      if (state == FETCH && cnt == '0)
         ramQ <= mem[{playBank, readIndex}];
   end

   assign SAMPLE_TICK = (state == FETCH) && (cnt == '0);
   assign READ_INDEX  = readIndex;
   assign PLAY_BANK   = playBank;
   assign UNDERRUN    = underrunQ;
   assign OVERRUN     = overrunQ;
   assign DAC_DATA    = dacData;
   assign DAC_WE_N    = weN;
   assign DAC_CS_N    = 1'b0;
   assign DAC_LDAC_N  = 1'b0;
   assign DAC_PD_N    = 1'b1;

endmodule

// File: tb/tb_dm_tlv5619_frame_player.sv
// Bench for dm_tlv5619_frame_player: directed frame scenarios then random traffic, all outputs
// compared each cycle against a phase/queue-level model of the player.
module tb_dm_tlv5619_frame_player;

   localparam int DW  = 12;
   localparam int AW  = 2;
   localparam int SP  = 32;
   localparam int WS  = 8;
   localparam int WL  = 8;
   localparam int MID = 2048;
   localparam int FR  = 4;
`ifdef DAC_UNDERRUN_MUTE_EN
   localparam bit MUTE = 1'b1;
`else
   localparam bit MUTE = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RST_N, ENABLE, WR_EN, WR_FRAME_DONE;
   logic [AW-1:0] WR_INDEX;
   logic [DW-1:0] WR_DATA;
   logic          SAMPLE_TICK, PLAY_BANK, UNDERRUN, OVERRUN, DAC_WE_N, DAC_CS_N, DAC_LDAC_N, DAC_PD_N;
   logic [AW-1:0] READ_INDEX;
   logic [DW-1:0] DAC_DATA;

   int checks = 0;
   int errors = 0;
   int ovCnt  = 0;

   dm_tlv5619_frame_player #(
      .DATA_W(DW), .ADDR_W(AW), .SAMPLE_PERIOD(SP), .WE_START(WS), .WE_LEN(WL), .MIDSCALE(MID)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .WR_EN(WR_EN), .WR_INDEX(WR_INDEX),
      .WR_DATA(WR_DATA), .WR_FRAME_DONE(WR_FRAME_DONE), .SAMPLE_TICK(SAMPLE_TICK),
      .READ_INDEX(READ_INDEX), .PLAY_BANK(PLAY_BANK), .UNDERRUN(UNDERRUN), .OVERRUN(OVERRUN),
      .DAC_DATA(DAC_DATA), .DAC_WE_N(DAC_WE_N), .DAC_CS_N(DAC_CS_N), .DAC_LDAC_N(DAC_LDAC_N),
      .DAC_PD_N(DAC_PD_N)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: phase = position within the sample period (-1 when stopped), frames as plain arrays.
   logic [DW-1:0] mMem [2][FR];
   bit            mKnown [2][FR];
   int            ph = -1;
   int            mIdx = 0;
   bit            mBank, mPend, mUnder, mOver, mMute, mValid, mDacKnown;
   logic [DW-1:0] mDac;

   always @(posedge CLK) begin
      if (WR_EN) begin
         mMem[int'(!mBank)][int'(WR_INDEX)] = WR_DATA;
         mKnown[int'(!mBank)][int'(WR_INDEX)] = 1'b1;
      end
      if (!RST_N) begin
         ph = -1; mIdx = 0; mBank = 0; mPend = 0; mUnder = 0; mOver = 0; mMute = 0;
         mDac = DW'(MID); mDacKnown = 1; mValid = 1;
      end else begin
         mUnder = 0;
         mOver  = 0;
         if (!ENABLE) ph = -1;
         else if (ph < 0) ph = 0;
         else if (ph == SP - 1) begin
            ph = 0;
            if (mIdx == FR - 1) begin
               if (mPend) begin mBank = !mBank; mPend = 0; mMute = 0; end
               else begin mUnder = 1; mMute = MUTE; end
            end
            mIdx = (mIdx + 1) % FR;
         end else ph = ph + 1;
         if (WR_FRAME_DONE) begin
            if (mPend) mOver = 1;
            mPend = 1;
         end
         if (ph == 2) begin
            mDac      = mMute ? DW'(MID) : mMem[int'(mBank)][mIdx];
            mDacKnown = mMute || mKnown[int'(mBank)][mIdx];
         end
      end
   end

   always @(negedge CLK) begin
      if (mValid) begin
         chk("tick", SAMPLE_TICK, (ph == 0));
         chk("we_n", DAC_WE_N, !(ph >= WS && ph < WS + WL));
         chk("read_index", READ_INDEX, mIdx);
         chk("play_bank", PLAY_BANK, mBank);
         chk("underrun", UNDERRUN, mUnder);
         chk("overrun", OVERRUN, mOver);
         if (mDacKnown) chk("dac_data", DAC_DATA, mDac);
      end
      if (OVERRUN) ovCnt++;
   end

   task automatic writeFrame(input logic [DW-1:0] base);
      for (int i = 0; i < FR; i++) begin
         WR_EN = 1'b1; WR_INDEX = AW'(i); WR_DATA = base + DW'(i);
         @(negedge CLK);
      end
      WR_EN = 1'b0;
   endtask

   task automatic pulseDone();
      WR_FRAME_DONE = 1'b1;
      @(negedge CLK);
      WR_FRAME_DONE = 1'b0;
   endtask

   // Returns at the negedge of the cycle where sample idx of the given bank starts (cnt = 0).
   task automatic waitSample(input int idx, input int bank);
      bit seen = 0;
      for (int n = 0; n < 1000 && !seen; n++) begin
         @(negedge CLK);
         seen = SAMPLE_TICK && (int'(READ_INDEX) == idx) && (int'(PLAY_BANK) == bank);
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL wait_sample: no tick for idx %0d bank %0d within 1000 cycles", idx, bank);
      end
   endtask

   initial begin
      int ovBase;
      RST_N = 0; ENABLE = 0; WR_EN = 0; WR_INDEX = '0; WR_DATA = '0; WR_FRAME_DONE = 0;
      repeat (2) @(negedge CLK);
      chk("rst_dac", DAC_DATA, 12'd2048);
      chk("rst_we", DAC_WE_N, 1);
      chk("rst_bank", PLAY_BANK, 0);
      chk("rst_idx", READ_INDEX, 0);
      chk("rst_flags", {SAMPLE_TICK, UNDERRUN, OVERRUN}, 0);
      chk("tie_offs", {DAC_CS_N, DAC_LDAC_N, DAC_PD_N}, 3'b001);
      RST_N = 1;
      @(negedge CLK);

      writeFrame(12'hA00);
      pulseDone();
      ENABLE = 1;
      @(negedge CLK);
      chk("enable_tick", SAMPLE_TICK, 1);

      // Swap into bank1 after bank0 idx 3
      for (int i = 0; i < FR; i++) begin
         waitSample(i, 1);
         if (i == 0) chk("swap_bank", PLAY_BANK, 1);
         repeat (2) @(negedge CLK);
         chk("swap_data", DAC_DATA, 12'hA00 + i);
      end
      writeFrame(12'h123);
      pulseDone();

      // Sample timing within one period
      waitSample(0, 0);
      for (int c = 1; c < SP; c++) begin
         @(negedge CLK);
         if (c == 2) chk("timing_data", DAC_DATA, 12'h123);
         chk("timing_we", DAC_WE_N, !(c >= 8 && c <= 15));
      end

      // Underrun: no frame queued
      waitSample(3, 0);
      repeat (SP) @(negedge CLK);
      chk("underrun_pulse", UNDERRUN, 1);
      chk("underrun_bank", PLAY_BANK, 0);
      chk("underrun_idx", READ_INDEX, 0);
      @(negedge CLK);
      chk("underrun_once", UNDERRUN, 0);
      @(negedge CLK);
      chk("replay_data", DAC_DATA, MUTE ? 12'd2048 : 12'h123);

      // Overrun: two frame-done pulses before the frame end
      ovBase = ovCnt;
      writeFrame(12'hB00);
      pulseDone();
      repeat (3) @(negedge CLK);
      pulseDone();
      repeat (2) @(negedge CLK);
      chk("overrun_count", ovCnt - ovBase, 1);

      // Frame-done exactly on the swap edge
      waitSample(0, 1);
      writeFrame(12'hC00);
      pulseDone();
      waitSample(3, 1);
      repeat (SP - 1) @(negedge CLK);
      WR_FRAME_DONE = 1;
      @(negedge CLK);
      WR_FRAME_DONE = 0;
      chk("simul_bank", PLAY_BANK, 0);
      chk("simul_flags", {UNDERRUN, OVERRUN}, 0);
      repeat (2) @(negedge CLK);
      chk("simul_data", DAC_DATA, 12'hC00);
      waitSample(3, 0);
      repeat (SP) @(negedge CLK);
      chk("simul_pending_swap", PLAY_BANK, 1);
      chk("simul_no_underrun", UNDERRUN, 0);

      // Enable drop during strobe, then re-enable
      repeat (10) @(negedge CLK);
      chk("strobe_low", DAC_WE_N, 0);
      ENABLE = 0;
      @(negedge CLK);
      chk("disable_we", DAC_WE_N, 1);
      chk("disable_idx", READ_INDEX, 0);
      repeat (4) @(negedge CLK);
      ENABLE = 1;
      @(negedge CLK);
      chk("reenable_tick", SAMPLE_TICK, 1);
      chk("reenable_bank", PLAY_BANK, 1);

      // Reset in the middle of a WE pulse
      repeat (9) @(negedge CLK);
      chk("pre_reset_we", DAC_WE_N, 0);
      RST_N = 0;
      @(negedge CLK);
      RST_N = 1;
      chk("reset_we", DAC_WE_N, 1);
      chk("reset_dac", DAC_DATA, 12'd2048);
      chk("reset_bank", PLAY_BANK, 0);

      // Random traffic against the model
      for (int n = 0; n < 5000; n++) begin
         if ($urandom_range(0, 299) == 0) ENABLE = ~ENABLE;
         WR_EN         = ($urandom_range(0, 3) == 0);
         WR_INDEX      = AW'($urandom_range(0, FR - 1));
         WR_DATA       = DW'($urandom);
         WR_FRAME_DONE = ($urandom_range(0, 119) == 0);
         RST_N         = ($urandom_range(0, 1999) != 0);
         @(negedge CLK);
      end
      RST_N = 1; WR_EN = 0; WR_FRAME_DONE = 0;
      repeat (4) @(negedge CLK);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
